// File: rtl/vec_ex.sv
// vec_ex: multi-cycle vector execute stage, LANES elements per EXEC cycle.
// Optional shifter (vsll/vsrl) is built only when VEC_EX_SHIFT_EN is defined.
module vec_ex #(
   parameter int VLEN  = 256,
   parameter int SEW   = 32,
   parameter int LANES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      in_funct6,
   input  logic [4:0]      in_vd,
   input  logic [VLEN-1:0] in_vs1,
   input  logic [VLEN-1:0] in_vs2,
   input  logic [31:0]     in_scalar,
   input  logic [10:0]     in_imm,
   input  logic [1:0]      in_src,
   input  logic            in_regwrite,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_vd,
   output logic [VLEN-1:0] out_data,
   output logic            out_regwrite,
   output logic            busy
);

   localparam int NE = VLEN / SEW;
   localparam int NC = NE / LANES;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;
   localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NC - 1);

   localparam logic [5:0] F_ADD  = 6'b000000;
   localparam logic [5:0] F_SUB  = 6'b000010;
   localparam logic [5:0] F_MINU = 6'b000100;
   localparam logic [5:0] F_MAXU = 6'b000110;
   localparam logic [5:0] F_AND  = 6'b001001;
   localparam logic [5:0] F_OR   = 6'b001010;
   localparam logic [5:0] F_XOR  = 6'b001011;
`ifdef VEC_EX_SHIFT_EN
   localparam logic [5:0] F_SLL  = 6'b100101;
   localparam logic [5:0] F_SRL  = 6'b101000;
`endif

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_e;

   typedef enum logic [3:0] {
      OP_NONE,
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_MINU,
      OP_MAXU,
      OP_SLL,
      OP_SRL
   } op_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   op_e             op_q;
   op_e             op_d;
   logic            vv_q;
   logic            vv_d;
   logic [SEW-1:0]  bsc_q;
   logic [SEW-1:0]  bsc_d;
   logic [VLEN-1:0] vs1_q;
   logic [VLEN-1:0] vs2_q;
   logic [VLEN-1:0] res_q;
   logic [VLEN-1:0] res_d;
   logic [4:0]      vd_q;
   logic            rw_q;
   logic            valid_q;
   logic            busy_q;
   logic            accept;

   logic [SEW-1:0]  opa  [LANES];
   logic [SEW-1:0]  opb  [LANES];
   logic [SEW-1:0]  lane [LANES];
   logic [IW-1:0]   off  [LANES];

   // Upper immediate bits carry no meaning for these operations.
   logic            unused_imm;
   assign unused_imm = ^in_imm[10:5];

   assign in_ready = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   assign out_valid    = valid_q;
   assign busy         = busy_q;
   assign out_vd       = vd_q;
   assign out_data     = res_q;
   assign out_regwrite = rw_q;

   // Map the incoming funct6 onto an internal op; NONE means unsupported.
   always_comb begin
      op_d = OP_NONE;
      case (in_funct6)
         F_ADD:   op_d = OP_ADD;
         F_SUB:   op_d = OP_SUB;
         F_AND:   op_d = OP_AND;
         F_OR:    op_d = OP_OR;
         F_XOR:   op_d = OP_XOR;
         F_MINU:  op_d = OP_MINU;
         F_MAXU:  op_d = OP_MAXU;
`ifdef VEC_EX_SHIFT_EN
         F_SLL:   op_d = OP_SLL;
         F_SRL:   op_d = OP_SRL;
`endif
         default: op_d = OP_NONE;
      endcase
   end

   // Resolve the broadcast operand B once, at acceptance time.
   always_comb begin
      vv_d  = (in_src == 2'd0);
      bsc_d = '0;
      case (in_src)
         2'd1:    bsc_d = SEW'(in_scalar);
         2'd2:    bsc_d = {{(SEW-5){in_imm[4]}}, in_imm[4:0]};
         default: bsc_d = '0;
      endcase
   end

   // Compute the current group of LANES elements and merge into the result.
   always_comb begin
      res_d = res_q;
      for (int l = 0; l < LANES; l++) begin
         off[l] = IW'((int'(cnt_q) * LANES + l) * SEW);
         opa[l] = vs2_q[off[l] +: SEW];
         opb[l] = vv_q ? vs1_q[off[l] +: SEW] : bsc_q;
         lane[l] = '0;
         case (op_q)
            OP_ADD:  lane[l] = opa[l] + opb[l];
            OP_SUB:  lane[l] = opa[l] - opb[l];
            OP_AND:  lane[l] = opa[l] & opb[l];
            OP_OR:   lane[l] = opa[l] | opb[l];
            OP_XOR:  lane[l] = opa[l] ^ opb[l];
            OP_MINU: lane[l] = (opa[l] < opb[l]) ? opa[l] : opb[l];
            OP_MAXU: lane[l] = (opa[l] < opb[l]) ? opb[l] : opa[l];
`ifdef VEC_EX_SHIFT_EN
            OP_SLL:  lane[l] = opa[l] << opb[l][4:0];
            OP_SRL:  lane[l] = opa[l] >> opb[l][4:0];
`endif
            default: lane[l] = '0;
         endcase
         res_d[off[l] +: SEW] = lane[l];
      end
   end

   // Control FSM plus all registered operands and outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NONE;
         vv_q    <= 1'b0;
         bsc_q   <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         res_q   <= '0;
         vd_q    <= '0;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (accept) begin
         state_q <= EXEC;
         cnt_q   <= '0;
         op_q    <= op_d;
         vv_q    <= vv_d;
         bsc_q   <= bsc_d;
         vs1_q   <= in_vs1;
         vs2_q   <= in_vs2;
         res_q   <= '0;
         vd_q    <= in_vd;
         rw_q    <= in_regwrite & (op_d != OP_NONE);
         valid_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            EXEC: begin
               res_q <= res_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_ex.sv
// tb_vec_ex: randomized self-checking bench for vec_ex.
// Reference model evaluates the element-wise operation with plain arithmetic.
module tb_vec_ex;

   localparam int VLEN  = 256;
   localparam int SEW   = 32;
   localparam int LANES = 2;
   localparam int NE    = VLEN / SEW;
   localparam int NC    = NE / LANES;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [5:0]      in_funct6 = '0;
   logic [4:0]      in_vd = '0;
   logic [VLEN-1:0] in_vs1 = '0;
   logic [VLEN-1:0] in_vs2 = '0;
   logic [31:0]     in_scalar = '0;
   logic [10:0]     in_imm = '0;
   logic [1:0]      in_src = '0;
   logic            in_regwrite = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [4:0]      out_vd;
   logic [VLEN-1:0] out_data;
   logic            out_regwrite;
   logic            busy;

   int n_pass  = 0;
   int n_total = 0;

   vec_ex #(.VLEN(VLEN), .SEW(SEW), .LANES(LANES)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_funct6    (in_funct6),
      .in_vd        (in_vd),
      .in_vs1       (in_vs1),
      .in_vs2       (in_vs2),
      .in_scalar    (in_scalar),
      .in_imm       (in_imm),
      .in_src       (in_src),
      .in_regwrite  (in_regwrite),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_vd       (out_vd),
      .out_data     (out_data),
      .out_regwrite (out_regwrite),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   function automatic logic [VLEN-1:0] model(
      input logic [5:0]      f6,
      input logic [VLEN-1:0] vs1,
      input logic [VLEN-1:0] vs2,
      input logic [31:0]     sc,
      input logic [10:0]     imm,
      input logic [1:0]      src
   );
      logic [VLEN-1:0] r;
      int unsigned a, b, y, ze;
      r  = '0;
      ze = {27'b0, imm[4:0]};
      for (int i = 0; i < NE; i++) begin
         a = vs2[i*SEW +: SEW];
         case (src)
            2'd0:    b = vs1[i*SEW +: SEW];
            2'd1:    b = sc;
            2'd2:    b = imm[4] ? (32'hFFFF_FFE0 | ze) : ze;
            default: b = 0;
         endcase
         case (f6)
            6'h00:   y = a + b;
            6'h02:   y = a - b;
            6'h09:   y = a & b;
            6'h0A:   y = a | b;
            6'h0B:   y = a ^ b;
            6'h04:   y = (a < b) ? a : b;
            6'h06:   y = (a > b) ? a : b;
`ifdef VEC_EX_SHIFT_EN
            6'h25:   y = a << (b % 32);
            6'h28:   y = a >> (b % 32);
`endif
            default: y = 0;
         endcase
         r[i*SEW +: SEW] = y;
      end
      return r;
   endfunction

   function automatic logic model_rw(input logic [5:0] f6, input logic rw);
      case (f6)
         6'h00, 6'h02, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h06: return rw;
`ifdef VEC_EX_SHIFT_EN
         6'h25, 6'h28: return rw;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] v;
      v = '0;
      for (int i = 0; i < NE; i++) v[i*SEW +: SEW] = $urandom;
      return v;
   endfunction

   function automatic logic [VLEN-1:0] ramp(input int unsigned base, input int unsigned step);
      logic [VLEN-1:0] v;
      v = '0;
      for (int i = 0; i < NE; i++) v[i*SEW +: SEW] = base + step * i;
      return v;
   endfunction

   task automatic drive_op(
      input logic [5:0]      f6,
      input logic [4:0]      vd,
      input logic [VLEN-1:0] v1,
      input logic [VLEN-1:0] v2,
      input logic [31:0]     sc,
      input logic [10:0]     imm,
      input logic [1:0]      src,
      input logic            rw
   );
      in_funct6   = f6;
      in_vd       = vd;
      in_vs1      = v1;
      in_vs2      = v2;
      in_scalar   = sc;
      in_imm      = imm;
      in_src      = src;
      in_regwrite = rw;
      in_valid    = 1'b1;
   endtask

   task automatic scramble();
      in_valid    = 1'b0;
      in_funct6   = 6'($urandom);
      in_vd       = 5'($urandom);
      in_vs1      = rand_vec();
      in_vs2      = rand_vec();
      in_scalar   = $urandom;
      in_imm      = 11'($urandom);
      in_src      = 2'($urandom);
      in_regwrite = 1'($urandom);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(
      input logic [5:0]      f6,
      input logic [4:0]      vd,
      input logic [VLEN-1:0] v1,
      input logic [VLEN-1:0] v2,
      input logic [31:0]     sc,
      input logic [10:0]     imm,
      input logic [1:0]      src,
      input logic            rw
   );
      int t;
      t = 0;
      drive_op(f6, vd, v1, v2, sc, imm, src, rw);
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      scramble();
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_hold out_valid=%0b busy=%0b required 0/0", out_valid, busy);
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", in_ready);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy);
      else n_pass++;
      n_total++;
      if (out_data !== '0) $display("FAIL rst_out_data got=%h exp=0", out_data);
      else n_pass++;
      n_total++;
      if (out_vd !== 5'd0 || out_regwrite !== 1'b0) $display("FAIL rst_vd_rw got=%0d/%0b exp=0/0", out_vd, out_regwrite);
      else n_pass++;
   endtask

   task automatic test_vadd_vv();
      int lat;
      logic [VLEN-1:0] exp_v;
      exp_v = ramp(32'h10, 1);
      send(6'h00, 5'd3, ramp(32'h10, 0), ramp(0, 1), 32'h0, 11'h0, 2'd0, 1'b1);
      n_total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL vadd_exec busy=%0b in_ready=%0b exp 1/0", busy, in_ready);
      else n_pass++;
      wait_result(lat);
      n_total++;
      if (lat !== NC) $display("FAIL vadd_latency got=%0d exp=%0d", lat, NC);
      else n_pass++;
      n_total++;
      if (out_data !== exp_v) $display("FAIL vadd_data got=%h exp=%h", out_data, exp_v);
      else n_pass++;
      n_total++;
      if (out_vd !== 5'd3 || out_regwrite !== 1'b1) $display("FAIL vadd_vd_rw got=%0d/%0b exp=3/1", out_vd, out_regwrite);
      else n_pass++;
      drain();
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL vadd_drain out_valid=%0b busy=%0b exp 0/0", out_valid, busy);
      else n_pass++;
   endtask

   task automatic test_vsub_vx();
      int lat;
      logic [VLEN-1:0] exp_v;
      exp_v = ramp(32'hFFFF_FFFE, 0);
      send(6'h02, 5'd7, rand_vec(), ramp(5, 0), 32'd7, 11'h0, 2'd1, 1'b1);
      wait_result(lat);
      n_total++;
      if (lat !== NC) $display("FAIL vsub_latency got=%0d exp=%0d", lat, NC);
      else n_pass++;
      n_total++;
      if (out_data !== exp_v) $display("FAIL vsub_data got=%h exp=%h", out_data, exp_v);
      else n_pass++;
      drain();
   endtask

   task automatic test_vi();
      int lat;
      logic [10:0] imm;
      logic [VLEN-1:0] ones;
      ones = ramp(32'hFFFF_FFFF, 0);
      imm = {6'($urandom), 5'h1F};
      send(6'h00, 5'd1, rand_vec(), ramp(1, 0), $urandom, imm, 2'd2, 1'b1);
      wait_result(lat);
      n_total++;
      if (out_data !== '0) $display("FAIL vadd_vi_data got=%h exp=0", out_data);
      else n_pass++;
      drain();
      send(6'h06, 5'd2, rand_vec(), rand_vec(), $urandom, imm, 2'd2, 1'b1);
      wait_result(lat);
      n_total++;
      if (out_data !== ones) $display("FAIL vmaxu_vi_data got=%h exp=%h", out_data, ones);
      else n_pass++;
      drain();
   endtask

   task automatic test_unsupported();
      int lat;
      logic [VLEN-1:0] exp_v;
      logic exp_rw;
      send(6'h3F, 5'd4, rand_vec(), rand_vec(), $urandom, 11'($urandom), 2'd0, 1'b1);
      wait_result(lat);
      n_total++;
      if (lat !== NC) $display("FAIL unsup_latency got=%0d exp=%0d", lat, NC);
      else n_pass++;
      n_total++;
      if (out_data !== '0 || out_regwrite !== 1'b0) $display("FAIL unsup_result data=%h rw=%0b exp 0/0", out_data, out_regwrite);
      else n_pass++;
      drain();
`ifdef VEC_EX_SHIFT_EN
      exp_v  = ramp(32'h10, 0);
      exp_rw = 1'b1;
`else
      exp_v  = '0;
      exp_rw = 1'b0;
`endif
      send(6'h25, 5'd5, rand_vec(), ramp(1, 0), $urandom, 11'd4, 2'd2, 1'b1);
      wait_result(lat);
      n_total++;
      if (lat !== NC) $display("FAIL vsll_latency got=%0d exp=%0d", lat, NC);
      else n_pass++;
      n_total++;
      if (out_data !== exp_v || out_regwrite !== exp_rw) $display("FAIL vsll_vi data=%h rw=%0b exp=%h/%0b", out_data, out_regwrite, exp_v, exp_rw);
      else n_pass++;
      drain();
   endtask

   task automatic test_random();
      int lat;
      logic [5:0] ops [10];
      logic [5:0] f6;
      logic [4:0] vd;
      logic [VLEN-1:0] v1, v2, exp_v;
      logic [31:0] sc;
      logic [10:0] imm;
      logic [1:0] src;
      logic rw;
      ops = '{6'h00, 6'h02, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h06, 6'h25, 6'h28, 6'h00};
      for (int k = 0; k < 24; k++) begin
         f6  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
         vd  = 5'($urandom);
         v1  = rand_vec();
         v2  = rand_vec();
         sc  = $urandom;
         imm = 11'($urandom);
         src = 2'($urandom);
         rw  = 1'($urandom);
         exp_v = model(f6, v1, v2, sc, imm, src);
         send(f6, vd, v1, v2, sc, imm, src, rw);
         wait_result(lat);
         n_total++;
         if (lat !== NC) $display("FAIL rand%0d_latency got=%0d exp=%0d", k, lat, NC);
         else n_pass++;
         n_total++;
         if (out_data !== exp_v) $display("FAIL rand%0d_data f6=%h src=%0d got=%h exp=%h", k, f6, src, out_data, exp_v);
         else n_pass++;
         n_total++;
         if (out_vd !== vd || out_regwrite !== model_rw(f6, rw)) $display("FAIL rand%0d_vd_rw got=%0d/%0b exp=%0d/%0b", k, out_vd, out_regwrite, vd, model_rw(f6, rw));
         else n_pass++;
         drain();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [VLEN-1:0] a1, a2, b1, b2, e1, e2;
      a1 = rand_vec(); a2 = rand_vec();
      b1 = rand_vec(); b2 = rand_vec();
      e1 = model(6'h00, a1, a2, 32'h0, 11'h0, 2'd0);
      e2 = model(6'h0B, b1, b2, 32'h0, 11'h0, 2'd0);
      send(6'h00, 5'd10, a1, a2, 32'h0, 11'h0, 2'd0, 1'b1);
      wait_result(lat);
      drive_op(6'h0B, 5'd11, b1, b2, 32'h0, 11'h0, 2'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_data !== e1 || in_ready !== 1'b0) $display("FAIL hold%0d valid=%0b ready=%0b data=%h exp 1/0/%h", k, out_valid, in_ready, out_data, e1);
         else n_pass++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%0b exp=1", in_ready);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      scramble();
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept valid=%0b busy=%0b exp 0/1", out_valid, busy);
      else n_pass++;
      wait_result(lat);
      n_total++;
      if (lat !== NC) $display("FAIL b2b_latency got=%0d exp=%0d", lat, NC);
      else n_pass++;
      n_total++;
      if (out_data !== e2 || out_vd !== 5'd11) $display("FAIL b2b_data got=%h/%0d exp=%h/11", out_data, out_vd, e2);
      else n_pass++;
      drain();
   endtask

   task automatic test_throughput();
      int c;
      logic [VLEN-1:0] a1, a2, b1, b2, e1, e2;
      a1 = rand_vec(); a2 = rand_vec();
      b1 = rand_vec(); b2 = rand_vec();
      e1 = model(6'h04, a1, a2, 32'h0, 11'h0, 2'd0);
      e2 = model(6'h0A, b1, b2, 32'h0, 11'h0, 2'd0);
      out_ready = 1'b1;
      drive_op(6'h04, 5'd12, a1, a2, 32'h0, 11'h0, 2'd0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive_op(6'h0A, 5'd13, b1, b2, 32'h0, 11'h0, 2'd0, 1'b1);
      c = 0;
      while (!out_valid && c < 30) begin
         @(negedge clk);
         c++;
      end
      n_total++;
      if (out_valid !== 1'b1 || out_data !== e1) $display("FAIL tput_first valid=%0b data=%h exp 1/%h", out_valid, out_data, e1);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      scramble();
      c = 1;
      while (!out_valid && c < 30) begin
         @(negedge clk);
         c++;
      end
      n_total++;
      if (c !== NC + 1) $display("FAIL tput_interval got=%0d exp=%0d", c, NC + 1);
      else n_pass++;
      n_total++;
      if (out_data !== e2) $display("FAIL tput_second got=%h exp=%h", out_data, e2);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL tput_idle valid=%0b busy=%0b exp 0/0", out_valid, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic seen;
      logic [VLEN-1:0] v1, v2, exp_v;
      send(6'h00, 5'd9, rand_vec(), ramp(32'h100, 3), 32'h0, 11'h0, 2'd0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_vd !== 5'd0 || out_regwrite !== 1'b0)
         $display("FAIL midrst_outputs valid=%0b busy=%0b vd=%0d rw=%0b data=%h exp all 0", out_valid, busy, out_vd, out_regwrite, out_data);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < NC + 3; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL midrst_no_valid got=%0b exp=0", seen);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1 || out_data !== '0) $display("FAIL midrst_idle in_ready=%0b data=%h exp 1/0", in_ready, out_data);
      else n_pass++;
      v1 = rand_vec();
      v2 = rand_vec();
      exp_v = model(6'h09, v1, v2, 32'h0, 11'h0, 2'd0);
      send(6'h09, 5'd14, v1, v2, 32'h0, 11'h0, 2'd0, 1'b1);
      wait_result(lat);
      n_total++;
      if (lat !== NC || out_data !== exp_v) $display("FAIL midrst_vand lat=%0d data=%h exp=%0d/%h", lat, out_data, NC, exp_v);
      else n_pass++;
      drain();
   endtask

   initial begin
      test_reset();
      test_vadd_vv();
      test_vsub_vx();
      test_vi();
      test_unsupported();
      test_back_to_back();
      test_throughput();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vec_ex.md
# vec_ex

Multi-cycle vector execute stage directly downstream of vector decode. Accepts one decoded vector arithmetic operation (vector operands, scalar/immediate operand, destination, write enable), computes an element-wise result over VLEN bits, LANES elements per cycle, and presents the full result vector to vector writeback. It uses a valid/ready handshake on both sides and holds at most one operation in flight.

## Interface
- VLEN, 256, vector register width in bits; must be a multiple of SEW*LANES
- SEW, 32, element width in bits; fixed, no vtype support
- LANES, 2, elements processed per EXEC cycle; legal values 1, 2, 4, 8
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode presents an operation
- in_ready  out  1  stage can accept an operation
- in_funct6  in  6  operation select (instruction[31:26])
- in_vd  in  5  destination vector register
- in_vs1  in  VLEN  vs1 register value
- in_vs2  in  VLEN  vs2 register value
- in_scalar  in  32  scalar x[rs1] value for .vx forms
- in_imm  in  11  immediate field; only bits [4:0] used
- in_src  in  2  operand-1 select: 0 = vs1 (vv), 1 = scalar (vx), 2 = simm5 (vi), 3 = treated as 0
- in_regwrite  in  1  write enable from decode
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_vd  out  5  destination register of result
- out_data  out  VLEN  result vector
- out_regwrite  out  1  write enable qualified by supported operation
- busy  out  1  high in EXEC or DONE

## Operation
- Element i occupies bits [i*SEW +: SEW]; NE = VLEN/SEW elements; NC = NE/LANES EXEC cycles.
- Operand A = vs2 element. Operand B = vs1 element (vv), in_scalar (vx, broadcast), or sign-extended in_imm[4:0] (vi, broadcast).
- funct6 map, result = A op B: 000000 vadd; 000010 vsub (A−B); 001001 vand; 001010 vor; 001011 vxor; 000100 vminu; 000110 vmaxu; 100101 vsll; 101000 vsrl. Shift amount = B[4:0]. Arithmetic wraps modulo 2^SEW; no saturation, no flags.
- Unsupported funct6: operation still runs the full NC cycles; out_data = 0, out_regwrite = 0.
- out_regwrite = latched in_regwrite AND supported.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready = 1. On in_valid: latch all inputs, count = 0, go to EXEC.
  - EXEC: each cycle compute elements count*LANES .. count*LANES+LANES−1 into the result register; count increments; on count == NC−1 go to DONE.
  - DONE: out_valid = 1; out_vd/out_data/out_regwrite stable. On out_ready: if in_valid, latch the new op and go to EXEC (in_ready = out_ready in DONE); else go to IDLE.
- EXEC: in_ready = 0, out_valid = 0.
- Result register cleared at acceptance, so no stale elements from a previous op survive.

## Timing
- Reset (async): state IDLE, count 0, out_valid 0, out_vd 0, out_data 0, out_regwrite 0, busy 0; in_ready = 1 once reset deasserts.
- Latency: acceptance on edge E0; out_valid high after edge E0+NC (default NC = 4).
- Throughput: back-to-back ops, one result every NC+1 cycles with out_ready held high.
- out_valid stays high and outputs hold while out_ready = 0; no input accepted during that time.
- Reset during EXEC or DONE: operation discarded, no out_valid pulse, outputs return to reset values.
- Inputs are sampled only on the acceptance edge; later changes to in_* are ignored.

## Configuration
- VEC_EX_SHIFT_EN defined: vsll/vsrl are supported as specified.
- Not defined: the shifter is omitted; funct6 100101 and 101000 are unsupported (out_data 0, out_regwrite 0); all other behaviour unchanged.

## Test plan
- vadd.vv, vs2 elements = i, vs1 elements = 0x10, regwrite 1, vd 3 -> after 4 cycles out_data elements = 0x10+i, out_vd 3, out_regwrite 1.
- vsub.vx, vs2 elements all 5, scalar 7 -> every element 0xFFFFFFFE (wraparound).
- vadd.vi with imm[4:0] = 5'b11111 -> B = 0xFFFFFFFF; vs2 element 1 gives 0; vmaxu.vi with the same imm gives 0xFFFFFFFF.
- Two ops back to back, out_ready low for 3 cycles after the first result -> first result held stable, in_ready 0; second op accepted in the cycle out_ready rises; second result follows NC cycles later.
- Reset asserted at EXEC count 2 -> out_valid never rises, all outputs 0, in_ready 1 after release; a following vand.vv completes correctly.
- funct6 = 111111, and vsll with VEC_EX_SHIFT_EN undefined -> completes in NC cycles, out_data 0, out_regwrite 0; with the macro defined, vsll.vi imm 4 on elements 1 -> 0x10.
